// File: rtl/router_pkg.sv
// Shared types and default widths for the mesh router input stage.
package router_pkg;

    localparam int unsigned COORD_W     = 30;
    localparam int unsigned PORT_W      = 30;
    localparam int unsigned FLIT_DATA_W = 64;

    typedef enum logic [1:0] {
        FlitBody     = 2'b00,
        FlitHead     = 2'b01,
        FlitTail     = 2'b10,
        FlitHeadTail = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        StIdle,
        StRoute,
        StActive
    } iu_state_e;

    typedef struct packed {
        flit_type_e             ftype;
        logic [FLIT_DATA_W-1:0] data;
    } flit_t;

    // Type codes: bit 0 marks a packet opener, bit 1 marks a packet closer.
    function automatic logic is_head(flit_type_e t);
        return t[0];
    endfunction

    function automatic logic is_tail(flit_type_e t);
        return t[1];
    endfunction

endpackage

// File: rtl/router_iu_fifo.sv
// Synchronous flit FIFO for the router input unit; head entry is read combinationally.
module router_iu_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter type         flit_t = router_pkg::flit_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push_i,
    input  logic  pop_i,
    input  flit_t wdata_i,
    output logic  full_o,
    output logic  empty_o,
    output flit_t head_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    flit_t           mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        full_o   = (count_q == (PtrW + 1)'(DEPTH));
        empty_o  = (count_q == '0);
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        // DEPTH is a power of two, so the pointers wrap on their own.
        wr_ptr_d = wr_ptr_q + PtrW'(do_push);
        rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
        count_d  = count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/router_input_unit.sv
// Mesh router per-port input stage: buffers flits, routes the head, streams the packet out.
// Define ROUTER_IU_CREDIT_EN for a credit-based upstream instead of valid/ready.
module router_input_unit #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned COORD_W = router_pkg::COORD_W,
    parameter int unsigned PORT_W  = router_pkg::PORT_W,
    parameter int unsigned DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
`ifdef ROUTER_IU_CREDIT_EN
    output logic               in_credit,
`else
    output logic               in_ready,
`endif
    input  logic [1:0]         in_type,
    input  logic [DATA_W-1:0]  in_data,
    output logic [COORD_W-1:0] route_dest_x,
    output logic [COORD_W-1:0] route_dest_y,
    input  logic [PORT_W-1:0]  route_outport,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_type,
    output logic [DATA_W-1:0]  out_data,
    output logic [PORT_W-1:0]  out_port,
    output logic               err_orphan,
    output logic               err_overflow
);

    import router_pkg::*;

    typedef struct packed {
        flit_type_e        ftype;
        logic [DATA_W-1:0] data;
    } iu_flit_t;

    iu_flit_t          wr_flit, head, head_vis;
    logic              fifo_full, fifo_empty;
    logic              push, pop, orphan;
    iu_state_e         state_q, state_d;
    logic [PORT_W-1:0] port_q, port_d;

    assign wr_flit = '{ftype: flit_type_e'(in_type), data: in_data};

    router_iu_fifo #(
        .DEPTH  (DEPTH),
        .flit_t (iu_flit_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_flit),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        pop       = 1'b0;
        orphan    = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    if (is_head(head.ftype)) begin
                        state_d = StRoute;
                    end else begin
                        pop    = 1'b1;
                        orphan = 1'b1;
                    end
                end
            end
            StRoute: begin
                port_d  = route_outport;
                state_d = StActive;
            end
            StActive: begin
                out_valid = !fifo_empty;
                if (out_valid && out_ready) begin
                    pop = 1'b1;
                    if (is_tail(head.ftype)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            port_q  <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
        end
    end

    // Unwritten FIFO storage must never leak out while empty.
    assign head_vis     = fifo_empty ? '0 : head;
    assign route_dest_x = head_vis.data[COORD_W-1:0];
    assign route_dest_y = head_vis.data[2*COORD_W-1:COORD_W];
    assign out_type     = head_vis.ftype;
    assign out_data     = head_vis.data;
    assign out_port     = port_q;
    assign err_orphan   = orphan;

`ifdef ROUTER_IU_CREDIT_EN
    logic credit_q, credit_d;

    assign push         = in_valid & ~fifo_full;
    assign err_overflow = in_valid & fifo_full;

    always_comb begin
        credit_d = pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q <= 1'b0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign in_credit = credit_q;
`else
    assign in_ready     = ~fifo_full;
    assign push         = in_valid & ~fifo_full;
    assign err_overflow = 1'b0;
`endif

endmodule
